// File: rtl/snake_head_mover.sv
// Snake head position generator for the 8x8 LED grid.
// Keys steer the head, a step counter paces moves, and a wall crossing latches the bump flag.
module snake_head_mover #(
  parameter int TICK_DIV  = 16,
  parameter int START_ROW = 3,
  parameter int START_COL = 3
) (
  input  logic            Clock,
  input  logic            reset,
  input  logic            L,
  input  logic            R,
  input  logic            U,
  input  logic            D,
  input  logic            run,
  output logic [7:0][7:0] head_position,
  output logic            tracking,
  output logic            snake,
  output logic [2:0]      row,
  output logic [2:0]      col,
  output logic [1:0]      state
);

  localparam int            CW = $clog2(TICK_DIV);
  localparam logic [CW-1:0] TC = CW'(TICK_DIV - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    MOVING = 2'd1,
    DEAD   = 2'd2
  } state_t;

  typedef enum logic [2:0] {
    DIR_NONE = 3'd0,
    DIR_U    = 3'd1,
    DIR_D    = 3'd2,
    DIR_L    = 3'd3,
    DIR_R    = 3'd4
  } dir_t;

  state_t        state_q;
  dir_t          dir_q;
  logic [CW-1:0] counter_q;

  dir_t          key_dir;
  dir_t          opp_dir;
  dir_t          eff_dir;
  logic          key_ok;
  logic          tick;
  logic          bump;
  logic [2:0]    nrow;
  logic [2:0]    ncol;

  function automatic logic [7:0][7:0] grid_decode(input logic [2:0] r, input logic [2:0] c);
    logic [7:0][7:0] g;
    g       = '0;
    g[r][c] = 1'b1;
    return g;
  endfunction

  assign state = state_q;

  // Priority pick happens first; if the winner reverses the snake, the whole key event is dropped.
  always_comb begin
    key_dir = DIR_NONE;
    if (U)      key_dir = DIR_U;
    else if (D) key_dir = DIR_D;
    else if (L) key_dir = DIR_L;
    else if (R) key_dir = DIR_R;

    opp_dir = DIR_NONE;
    case (dir_q)
      DIR_U:   opp_dir = DIR_D;
      DIR_D:   opp_dir = DIR_U;
      DIR_L:   opp_dir = DIR_R;
      DIR_R:   opp_dir = DIR_L;
      default: opp_dir = DIR_NONE;
    endcase

    key_ok  = (key_dir != DIR_NONE) && (key_dir != opp_dir);
    eff_dir = (state_q == MOVING && key_ok) ? key_dir : dir_q;
    tick    = run && (counter_q == TC);
  end

  // Next head position for the effective direction; a step off the grid is a bump, never a wrap.
  always_comb begin
    nrow = row;
    ncol = col;
    bump = 1'b0;
    case (eff_dir)
      DIR_U: if (row == 3'd0) bump = 1'b1; else nrow = row - 3'd1;
      DIR_D: if (row == 3'd7) bump = 1'b1; else nrow = row + 3'd1;
      DIR_L: if (col == 3'd0) bump = 1'b1; else ncol = col - 3'd1;
      DIR_R: if (col == 3'd7) bump = 1'b1; else ncol = col + 3'd1;
      default: bump = 1'b0;
    endcase
  end

  always_ff @(posedge Clock or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      dir_q         <= DIR_NONE;
      counter_q     <= '0;
      row           <= 3'(START_ROW);
      col           <= 3'(START_COL);
      head_position <= grid_decode(3'(START_ROW), 3'(START_COL));
      tracking      <= 1'b0;
      snake         <= 1'b0;
    end else begin
      tracking <= 1'b0;
      case (state_q)
        IDLE: begin
          counter_q <= '0;
          if (key_ok) begin
            dir_q   <= key_dir;
            state_q <= MOVING;
          end
        end
        MOVING: begin
          dir_q <= eff_dir;
          if (run) begin
            if (tick) begin
              counter_q <= '0;
              tracking  <= 1'b1;
              if (bump) begin
                snake   <= 1'b1;
                state_q <= DEAD;
              end else begin
                row           <= nrow;
                col           <= ncol;
                head_position <= grid_decode(nrow, ncol);
              end
            end else begin
              counter_q <= counter_q + 1'b1;
            end
          end
        end
        // Position is frozen, but the strobe keeps pacing so the overlay can blink.
        DEAD: begin
          if (run) begin
            if (tick) begin
              counter_q <= '0;
              tracking  <= 1'b1;
            end else begin
              counter_q <= counter_q + 1'b1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_snake_head_mover.sv
// Bench for snake_head_mover: per-cycle scoreboard against an integer grid model,
// plus directed checks at the moves, the wall bump, the pause and asynchronous reset.
module tb_snake_head_mover;

  localparam int TD = 4;
  localparam int W  = 74;

  logic            Clock;
  logic            reset;
  logic            L, R, U, D, run;
  logic [7:0][7:0] head_position;
  logic            tracking;
  logic            snake;
  logic [2:0]      row;
  logic [2:0]      col;
  logic [1:0]      state;

  logic [W-1:0] exp_q[$];

  int n_checks = 0;
  int n_errors = 0;

  int m_row, m_col, m_cnt, m_state, m_dir, m_trk, m_snake;

  snake_head_mover #(.TICK_DIV(TD), .START_ROW(3), .START_COL(3)) dut (
    .Clock(Clock),
    .reset(reset),
    .L(L),
    .R(R),
    .U(U),
    .D(D),
    .run(run),
    .head_position(head_position),
    .tracking(tracking),
    .snake(snake),
    .row(row),
    .col(col),
    .state(state)
  );

  initial begin
    Clock = 1'b0;
    forever #5 Clock = ~Clock;
  end

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_row = 3; m_col = 3; m_cnt = 0; m_state = 0; m_dir = 0; m_trk = 0; m_snake = 0;
  endtask

  // dir codes: 0 none, 1 up, 2 down, 3 left, 4 right; state codes: 0 idle, 1 moving, 2 dead
  task automatic model_step(input logic u, input logic d, input logic l, input logic r, input logic rn);
    int k, opp, nr, nc;
    bit kv;
    k   = u ? 1 : d ? 2 : l ? 3 : r ? 4 : 0;
    opp = (m_dir == 1) ? 2 : (m_dir == 2) ? 1 : (m_dir == 3) ? 4 : (m_dir == 4) ? 3 : 0;
    kv  = (k != 0) && (k != opp);
    m_trk = 0;
    if (m_state == 0) begin
      m_cnt = 0;
      if (kv) begin
        m_dir   = k;
        m_state = 1;
      end
    end else begin
      if (m_state == 1 && kv) m_dir = k;
      if (rn) begin
        if (m_cnt == TD - 1) begin
          m_cnt = 0;
          m_trk = 1;
          if (m_state == 1) begin
            nr = m_row + ((m_dir == 2) ? 1 : (m_dir == 1) ? -1 : 0);
            nc = m_col + ((m_dir == 4) ? 1 : (m_dir == 3) ? -1 : 0);
            if (nr < 0 || nr > 7 || nc < 0 || nc > 7) begin
              m_snake = 1;
              m_state = 2;
            end else begin
              m_row = nr;
              m_col = nc;
            end
          end
        end else begin
          m_cnt++;
        end
      end
    end
  endtask

  function automatic logic [W-1:0] model_pack();
    logic [63:0] hp;
    hp = 64'd1 << (m_row * 8 + m_col);
    return {hp, 1'(m_trk), 1'(m_snake), 3'(m_row), 3'(m_col), 2'(m_state)};
  endfunction

  task automatic cycle(input logic u, input logic d, input logic l, input logic r, input logic rn);
    logic [W-1:0] e;
    @(negedge Clock);
    U = u; D = d; L = l; R = r; run = rn;
    model_step(u, d, l, r, rn);
    exp_q.push_back(model_pack());
    @(posedge Clock);
    #1;
    check("sb_depth", 64'(exp_q.size()), 64'd1);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("head_position", head_position, e[73:10]);
      check("tracking", 64'(tracking), 64'(e[9]));
      check("snake", 64'(snake), 64'(e[8]));
      check("row", 64'(row), 64'(e[7:5]));
      check("col", 64'(col), 64'(e[4:2]));
      check("state", 64'(state), 64'(e[1:0]));
    end
  endtask

  task automatic idle_cycles(input int n, input logic rn);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0, 1'b0, rn);
  endtask

  // Reset raised between edges; outputs must be back at the start position before any clock edge.
  task automatic async_reset(input string tag);
    @(negedge Clock);
    U = 0; D = 0; L = 0; R = 0; run = 1;
    #2 reset = 1'b1;
    #1;
    model_reset();
    check({tag, "_row"}, 64'(row), 64'd3);
    check({tag, "_col"}, 64'(col), 64'd3);
    check({tag, "_hp"}, head_position, 64'd1 << 27);
    check({tag, "_snake"}, 64'(snake), 64'd0);
    check({tag, "_tracking"}, 64'(tracking), 64'd0);
    @(negedge Clock);
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    U = 0; D = 0; L = 0; R = 0; run = 1;
    model_reset();
    repeat (3) @(negedge Clock);
    check("por_hp", head_position, 64'd1 << 27);
    check("por_tracking", 64'(tracking), 64'd0);
    check("por_snake", 64'(snake), 64'd0);
    reset = 1'b0;

    // Idle: nothing moves, no strobe
    idle_cycles(20, 1'b1);
    check("idle_row", 64'(row), 64'd3);
    check("idle_col", 64'(col), 64'd3);

    // R pulse, first move four edges later, then every four
    cycle(0, 0, 0, 1, 1);
    idle_cycles(4, 1'b1);
    check("first_col", 64'(col), 64'd4);
    check("first_tracking", 64'(tracking), 64'd1);
    idle_cycles(4, 1'b1);
    check("second_col", 64'(col), 64'd5);
    check("second_row", 64'(row), 64'd3);

    // Reverse key ignored, then turn up
    cycle(0, 0, 1, 0, 1);
    idle_cycles(3, 1'b1);
    check("rev_ignored_col", 64'(col), 64'd6);
    cycle(1, 0, 0, 0, 1);
    idle_cycles(3, 1'b1);
    check("turn_row", 64'(row), 64'd2);
    check("turn_col", 64'(col), 64'd6);

    async_reset("rst_moving");

    // Run into the right wall
    cycle(0, 0, 0, 1, 1);
    idle_cycles(16, 1'b1);
    check("wall_col7", 64'(col), 64'd7);
    check("wall_snake_pre", 64'(snake), 64'd0);
    idle_cycles(4, 1'b1);
    check("bump_snake", 64'(snake), 64'd1);
    check("bump_col", 64'(col), 64'd7);
    check("bump_tracking", 64'(tracking), 64'd1);
    cycle(0, 1, 0, 0, 1);
    idle_cycles(11, 1'b1);
    check("dead_row", 64'(row), 64'd3);
    check("dead_col", 64'(col), 64'd7);
    check("dead_snake", 64'(snake), 64'd1);

    async_reset("rst_dead");

    // U and R together: up wins
    cycle(1, 0, 0, 1, 1);
    idle_cycles(4, 1'b1);
    check("prio_row", 64'(row), 64'd2);
    check("prio_col", 64'(col), 64'd3);

    // Pause mid-count with a key latched during the pause
    idle_cycles(2, 1'b1);
    cycle(0, 0, 1, 0, 0);
    idle_cycles(9, 1'b0);
    check("pause_row", 64'(row), 64'd2);
    check("pause_col", 64'(col), 64'd3);
    check("pause_tracking", 64'(tracking), 64'd0);
    idle_cycles(1, 1'b1);
    check("resume_hold_col", 64'(col), 64'd3);
    idle_cycles(1, 1'b1);
    check("resume_col", 64'(col), 64'd2);
    check("resume_tracking", 64'(tracking), 64'd1);

    // Random keys and run gaps, with periodic resets
    for (int s = 0; s < 4; s++) begin
      async_reset("rst_rand");
      for (int i = 0; i < 80; i++) begin
        cycle($urandom_range(0, 9) == 0, $urandom_range(0, 9) == 0,
              $urandom_range(0, 9) == 0, $urandom_range(0, 9) == 0,
              $urandom_range(0, 7) != 0);
      end
    end

    check("sb_drained", 64'(exp_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
